// File: rtl/wb_pkg.sv
// Shared result-write types for the arbiter and the results buffer.
// One result_t bundle per completed execution-unit result.
package wb_pkg;

  localparam int ROBID_W = 4;
  localparam int DATA_W  = 8;

  localparam int FLAG_BRANCH    = 0;
  localparam int FLAG_HALT      = 4;
  localparam int FLAG_NOT_TAKEN = 5;

  typedef struct packed {
    logic [ROBID_W-1:0] robid;
    logic [DATA_W-1:0]  flags;
    logic [DATA_W-1:0]  wbs;
    logic [DATA_W-1:0]  value;
  } result_t;

endpackage

// File: rtl/wb_arbiter_if.sv
// Source-side and results-buffer-side signals of the write arbiter.
// master drives results in, slave is the arbiter itself.
interface wb_arbiter_if
  import wb_pkg::*;
#(
  parameter int N_SRC = 3
) ();

  logic                            flush;
  logic [N_SRC-1:0]                src_valid;
  logic [N_SRC-1:0]                src_ready;
  logic [N_SRC-1:0][ROBID_W-1:0]   src_robid;
  logic [N_SRC-1:0][DATA_W-1:0]    src_flags;
  logic [N_SRC-1:0][DATA_W-1:0]    src_wbs;
  logic [N_SRC-1:0][DATA_W-1:0]    src_value;
  logic                            rob_transmit;
  logic [ROBID_W-1:0]              robid;
  logic [DATA_W-1:0]               flags;
  logic [DATA_W-1:0]               wbs;
  logic [DATA_W-1:0]               value;
  logic                            busy;

  modport master (
    output flush, src_valid, src_robid,
    output src_flags, src_wbs, src_value,
    input  src_ready, rob_transmit, robid,
    input  flags, wbs, value, busy
  );

  modport slave (
    input  flush, src_valid, src_robid,
    input  src_flags, src_wbs, src_value,
    output src_ready, rob_transmit, robid,
    output flags, wbs, value, busy
  );

endinterface

// File: rtl/wb_fifo.sv
// Per-source result FIFO; flush and reset empty it in one edge.
// Storage is not reset, only pointers and count.
module wb_fifo
  import wb_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       flush,
  input  logic                       push,
  input  logic                       pop,
  input  result_t                    din,
  output result_t                    dout,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       full,
  output logic                       empty
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  result_t       mem [DEPTH];
  logic [PW-1:0] wr;
  logic [PW-1:0] rd;

  function automatic logic [PW-1:0] inc(
    input logic [PW-1:0] p
  );
    return (int'(p) == DEPTH - 1) ? '0 : p + 1'b1;
  endfunction

  always_ff @(posedge clk) begin
    if (push) mem[wr] <= din;
  end

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wr    <= '0;
      rd    <= '0;
      count <= '0;
    end else begin
      if (push) wr <= inc(wr);
      if (pop)  rd <= inc(rd);
      unique case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  assign dout  = mem[rd];
  assign full  = (count == CW'(DEPTH));
  assign empty = (count == '0);

endmodule

// File: rtl/wb_arbiter.sv
// Round-robin merge of per-source result FIFOs onto the
// results-buffer write port, one registered result per cycle.
module wb_arbiter
  import wb_pkg::*;
#(
  parameter int N_SRC = 3,
  parameter int DEPTH = 2
) (
  input  logic         clk,
  input  logic         rst,
  wb_arbiter_if.slave  bus
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int RW = (N_SRC > 1) ? $clog2(N_SRC) : 1;

  result_t          head  [N_SRC];
  logic [CW-1:0]    count [N_SRC];
  logic [N_SRC-1:0] push;
  logic [N_SRC-1:0] pop;
  logic [N_SRC-1:0] full;
  logic [N_SRC-1:0] empty;
  logic [N_SRC-1:0] held;

  logic             grant;
  logic [RW-1:0]    winner;
  logic [RW-1:0]    rr_ptr;
  logic             tx;
  result_t          out;

  function automatic logic [RW-1:0] wrap(input int x);
    return RW'((x >= N_SRC) ? x - N_SRC : x);
  endfunction

  for (genvar i = 0; i < N_SRC; i++) begin : g_src
    result_t din;

    assign din = {bus.src_robid[i], bus.src_flags[i],
                  bus.src_wbs[i], bus.src_value[i]};

    // Ready ignores a same-cycle pop so it never depends on grant.
    assign bus.src_ready[i] = !rst && !bus.flush && !full[i];
    assign push[i] = bus.src_valid[i] && bus.src_ready[i];
    assign pop[i]  = grant && (int'(winner) == i);
    assign held[i] = (count[i] != '0);

    wb_fifo #(.DEPTH(DEPTH)) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .flush (bus.flush),
      .push  (push[i]),
      .pop   (pop[i]),
      .din   (din),
      .dout  (head[i]),
      .count (count[i]),
      .full  (full[i]),
      .empty (empty[i])
    );
  end

  always_comb begin
    grant  = 1'b0;
    winner = '0;
    for (int k = 0; k < N_SRC; k++) begin
      if (!grant && !empty[wrap(int'(rr_ptr) + k)]) begin
        grant  = 1'b1;
        winner = wrap(int'(rr_ptr) + k);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      tx     <= 1'b0;
      out    <= '0;
      rr_ptr <= '0;
    end else if (bus.flush) begin
      tx     <= 1'b0;
      rr_ptr <= '0;
    end else if (grant) begin
      tx     <= 1'b1;
      out    <= head[winner];
      rr_ptr <= wrap(int'(winner) + 1);
    end else begin
      tx     <= 1'b0;
    end
  end

  assign bus.rob_transmit = tx;
  assign bus.robid        = out.robid;
  assign bus.flags        = out.flags;
  assign bus.wbs          = out.wbs;
  assign bus.value        = out.value;
  assign bus.busy         = tx || (|held);

endmodule

// File: tb/tb_wb_arbiter.sv
// Directed cycle table plus a single-result latency sequence
// for the results-buffer write arbiter.
module tb_wb_arbiter;
  import wb_pkg::*;

  localparam int N = 3;

  logic clk = 1'b0;
  logic rst = 1'b1;

  always #5 clk = ~clk;

  wb_arbiter_if #(.N_SRC(N)) bus ();

  wb_arbiter #(.N_SRC(N), .DEPTH(2)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    logic       r;
    logic       f;
    logic [2:0] v;
    logic [3:0] i0;
    logic [3:0] i1;
    logic [3:0] i2;
    logic [2:0] rdy;
    logic       tx;
    logic [3:0] id;
    logic       busy;
  } vec_t;

  vec_t tv [$];
  int   n_vec = 0;
  int   n_err = 0;

  function automatic result_t gen(input logic [3:0] id);
    result_t r;
    r = '0;
    if (id != 4'd0) begin
      r.robid = id;
      r.flags = {id, ~id};
      r.wbs   = {~id, id};
      r.value = 8'(int'(id) * 13 + 1);
    end
    return r;
  endfunction

  task automatic add(
    input logic r, input logic f,
    input logic [2:0] v,
    input int i0, input int i1, input int i2,
    input logic [2:0] rdy, input logic tx,
    input int id, input logic busy
  );
    vec_t e;
    e.r = r; e.f = f; e.v = v;
    e.i0 = 4'(i0); e.i1 = 4'(i1); e.i2 = 4'(i2);
    e.rdy = rdy; e.tx = tx;
    e.id = 4'(id); e.busy = busy;
    tv.push_back(e);
  endtask

  task automatic set_src(input int i, input logic [3:0] id);
    result_t g;
    g = gen(id);
    bus.src_robid[i] = id;
    bus.src_flags[i] = g.flags;
    bus.src_wbs[i]   = g.wbs;
    bus.src_value[i] = g.value;
  endtask

  task automatic chk(
    input string name,
    input logic [31:0] act,
    input logic [31:0] exp
  );
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  initial begin
    result_t e;

    // r f  v      i0 i1 i2  rdy    tx id busy
    add(1,0,3'b000, 0, 0, 0,3'b000,0, 0,0);
    add(0,0,3'b111, 1, 2, 3,3'b111,0, 0,0);
    add(0,0,3'b000, 0, 0, 0,3'b111,0, 0,1);
    add(0,0,3'b000, 0, 0, 0,3'b111,1, 1,1);
    add(0,0,3'b000, 0, 0, 0,3'b111,1, 2,1);
    add(0,0,3'b000, 0, 0, 0,3'b111,1, 3,1);
    add(0,0,3'b101, 4, 0, 5,3'b111,0, 3,0);
    add(0,0,3'b101, 6, 0, 7,3'b111,0, 3,1);
    add(0,0,3'b101, 8, 0, 9,3'b011,1, 4,1);
    add(0,0,3'b101,10, 0,11,3'b110,1, 5,1);
    add(0,0,3'b000, 0, 0, 0,3'b011,1, 6,1);
    add(0,0,3'b000, 0, 0, 0,3'b111,1, 7,1);
    add(0,0,3'b000, 0, 0, 0,3'b111,1, 8,1);
    add(0,0,3'b000, 0, 0, 0,3'b111,1,11,1);
    add(0,0,3'b111,12,13,14,3'b111,0,11,0);
    add(0,0,3'b010, 0,15, 0,3'b111,0,11,1);
    add(0,0,3'b010, 0, 1, 0,3'b101,1,12,1);
    add(0,0,3'b010, 0, 1, 0,3'b111,1,13,1);
    add(0,0,3'b000, 0, 0, 0,3'b101,1,14,1);
    add(0,0,3'b000, 0, 0, 0,3'b111,1,15,1);
    add(0,0,3'b000, 0, 0, 0,3'b111,1, 1,1);
    add(0,0,3'b011, 2, 3, 0,3'b111,0, 1,0);
    add(0,0,3'b111, 5, 7, 6,3'b111,0, 1,1);
    add(0,1,3'b111, 7, 8, 9,3'b000,1, 2,1);
    add(0,0,3'b101,10, 0,11,3'b111,0, 2,0);
    add(0,0,3'b000, 0, 0, 0,3'b111,0, 2,1);
    add(0,0,3'b000, 0, 0, 0,3'b111,1,10,1);
    add(0,0,3'b000, 0, 0, 0,3'b111,1,11,1);
    add(0,0,3'b111, 1, 2, 3,3'b111,0,11,0);
    add(0,0,3'b000, 0, 0, 0,3'b111,0,11,1);
    add(1,0,3'b111, 1, 2, 3,3'b000,1, 1,1);
    add(1,0,3'b111, 1, 2, 3,3'b000,0, 0,0);
    add(0,0,3'b100, 0, 0, 5,3'b111,0, 0,0);
    add(0,0,3'b000, 0, 0, 0,3'b111,0, 0,1);
    add(0,0,3'b000, 0, 0, 0,3'b111,1, 5,1);
    add(0,0,3'b000, 0, 0, 0,3'b111,0, 5,0);

    bus.flush     = 1'b0;
    bus.src_valid = '0;
    for (int i = 0; i < N; i++) set_src(i, 4'd0);
    rst = 1'b1;
    repeat (2) @(posedge clk);

    for (int k = 0; k < tv.size(); k++) begin
      @(negedge clk);
      rst           = tv[k].r;
      bus.flush     = tv[k].f;
      bus.src_valid = tv[k].v;
      set_src(0, tv[k].i0);
      set_src(1, tv[k].i1);
      set_src(2, tv[k].i2);
      #1;
      e = gen(tv[k].id);
      chk($sformatf("v%0d rdy", k),
          32'(bus.src_ready), 32'(tv[k].rdy));
      chk($sformatf("v%0d tx", k),
          32'(bus.rob_transmit), 32'(tv[k].tx));
      chk($sformatf("v%0d busy", k),
          32'(bus.busy), 32'(tv[k].busy));
      chk($sformatf("v%0d robid", k),
          32'(bus.robid), 32'(e.robid));
      chk($sformatf("v%0d flags", k),
          32'(bus.flags), 32'(e.flags));
      chk($sformatf("v%0d wbs", k),
          32'(bus.wbs), 32'(e.wbs));
      chk($sformatf("v%0d value", k),
          32'(bus.value), 32'(e.value));
      @(posedge clk);
    end

    @(negedge clk);
    rst              = 1'b0;
    bus.flush        = 1'b0;
    bus.src_valid    = 3'b001;
    bus.src_robid[0] = 4'd3;
    bus.src_flags[0] = 8'h00;
    bus.src_wbs[0]   = 8'h52;
    bus.src_value[0] = 8'hA7;
    #1;
    chk("single rdy", 32'(bus.src_ready[0]), 32'd1);
    @(posedge clk);
    @(negedge clk);
    bus.src_valid = '0;
    #1;
    chk("single t0 tx", 32'(bus.rob_transmit), 32'd0);
    chk("single t0 busy", 32'(bus.busy), 32'd1);
    @(posedge clk);
    @(negedge clk);
    chk("single tx", 32'(bus.rob_transmit), 32'd1);
    chk("single robid", 32'(bus.robid), 32'd3);
    chk("single flags", 32'(bus.flags), 32'h00);
    chk("single wbs", 32'(bus.wbs), 32'h52);
    chk("single value", 32'(bus.value), 32'hA7);
    @(posedge clk);
    @(negedge clk);
    chk("single t2 tx", 32'(bus.rob_transmit), 32'd0);
    chk("single t2 busy", 32'(bus.busy), 32'd0);
    chk("single hold", 32'(bus.value), 32'hA7);

    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec, n_err);
    $finish;
  end

endmodule
